// File: rtl/aes_ctrl_pkg.sv
// Shared constants, types and round-key index helpers for the AES round-key sequencer.
package aes_ctrl_pkg;

    localparam int unsigned BLK_W      = 128;
    localparam int unsigned RK_NUM     = 15;
    localparam int unsigned RK_IDX_W   = 4;
    localparam int unsigned ISSUE_LAST = 13;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef logic [BLK_W-1:0]    blk_t;
    typedef logic [RK_IDX_W-1:0] rk_idx_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic    en;
        rk_idx_t idx;
        blk_t    data;
    } rk_wr_t;

    // Key driven on key0 for a given issue count: forward to encrypt, reverse to decrypt.
    function automatic rk_idx_t rk_idx0(input logic mode, input rk_idx_t cnt);
        if (cnt == '0) begin
            return (mode == MODE_ENC) ? '0 : RK_IDX_W'(RK_NUM - 1);
        end
        return (mode == MODE_ENC) ? cnt + RK_IDX_W'(1) : RK_IDX_W'(ISSUE_LAST) - cnt;
    endfunction

    function automatic rk_idx_t rk_idx1(input logic mode);
        return (mode == MODE_DEC) ? RK_IDX_W'(ISSUE_LAST) : RK_IDX_W'(1);
    endfunction

endpackage

// File: rtl/aes_rk_store.sv
// 15 x 128 round-key register file: one write port, two write-first combinational read ports.
module aes_rk_store
    import aes_ctrl_pkg::*;
(
    input  logic              clk,
    input  rk_wr_t            wr,
    input  logic [RK_IDX_W-1:0] rd_idx0,
    input  logic [RK_IDX_W-1:0] rd_idx1,
    output logic [BLK_W-1:0]  rd_data0_c,
    output logic [BLK_W-1:0]  rd_data1_c
);

    blk_t mem [RK_NUM];
    logic wr_hit;

    assign wr_hit = wr.en && (wr.idx < RK_IDX_W'(RK_NUM));

    // No reset: keys survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[wr.idx] <= wr.data;
        end
    end

    // A write in the request cycle is forwarded so the request sees the new key.
    always_comb begin
        rd_data0_c = '0;
        rd_data1_c = '0;
        if (wr_hit && (wr.idx == rd_idx0)) begin
            rd_data0_c = wr.data;
        end else if (rd_idx0 < RK_IDX_W'(RK_NUM)) begin
            rd_data0_c = mem[rd_idx0];
        end
        if (wr_hit && (wr.idx == rd_idx1)) begin
            rd_data1_c = wr.data;
        end else if (rd_idx1 < RK_IDX_W'(RK_NUM)) begin
            rd_data1_c = mem[rd_idx1];
        end
    end

endmodule

// File: rtl/aes_round_key_sequencer.sv
// Round-key sequencer in front of the AES-256 block core; all outputs registered.
// Optional AES_RK_VALID_TRACK_EN: hold off requests until all 15 round keys are written.
module aes_round_key_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                inClk,
    input  logic                inRstN,
    input  logic                inKeyWr,
    input  logic [RK_IDX_W-1:0] inKeyIdx,
    input  logic [BLK_W-1:0]    inKeyData,
    input  logic                inReqValid,
    input  logic                inReqMode,
    input  logic [BLK_W-1:0]    inReqData,
    output logic                outReqReady,
    output logic                outCoreDataWr,
    output logic [BLK_W-1:0]    outCoreData,
    output logic                outCoreAesMode,
    output logic [BLK_W-1:0]    outCoreKeyData0,
    output logic [BLK_W-1:0]    outCoreKeyData1,
    input  logic                inCoreBusy,
    input  logic [BLK_W-1:0]    inCoreData,
    output logic                outResValid,
    output logic [BLK_W-1:0]    outResData,
    input  logic                inResReady,
    output logic                outErr
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t          state, state_nxt;
    rk_idx_t         cnt, cnt_nxt;
    logic [TO_W-1:0] tcnt, tcnt_nxt;
    logic            mode, mode_nxt;
    blk_t            blk, blk_nxt;

    logic    req_fire_c, key_bad_c, keys_ready_c, capture_c, timeout_c;
    rk_wr_t  key_wr_c;
    rk_idx_t rd_idx0_c, rd_idx1_c;
    blk_t    rk0_c, rk1_c;

    logic req_ready_c, core_wr_c, core_mode_c, res_valid_c, err_c;
    blk_t core_data_c, key0_c, key1_c, res_data_c;

    assign req_fire_c = outReqReady && inReqValid;
    assign key_bad_c  = inKeyWr && (state != IDLE);
    assign key_wr_c   = '{en: inKeyWr && (state == IDLE), idx: inKeyIdx, data: inKeyData};

`ifdef AES_RK_VALID_TRACK_EN
    logic [RK_NUM-1:0] rk_valid, rk_valid_nxt;

    assign rk_valid_nxt = rk_valid | (key_wr_c.en ? RK_NUM'(1) << inKeyIdx : '0);
    assign keys_ready_c = &rk_valid_nxt;

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) rk_valid <= '0;
        else         rk_valid <= rk_valid_nxt;
    end
`else
    assign keys_ready_c = 1'b1;
`endif

    aes_rk_store u_store (
        .clk        (inClk),
        .wr         (key_wr_c),
        .rd_idx0    (rd_idx0_c),
        .rd_idx1    (rd_idx1_c),
        .rd_data0_c (rk0_c),
        .rd_data1_c (rk1_c)
    );

    // State and output registers.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state           <= IDLE;
            cnt             <= '0;
            tcnt            <= '0;
            mode            <= MODE_ENC;
            blk             <= '0;
            outReqReady     <= 1'b0;
            outCoreDataWr   <= 1'b0;
            outCoreData     <= '0;
            outCoreAesMode  <= 1'b0;
            outCoreKeyData0 <= '0;
            outCoreKeyData1 <= '0;
            outResValid     <= 1'b0;
            outResData      <= '0;
            outErr          <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            tcnt            <= tcnt_nxt;
            mode            <= mode_nxt;
            blk             <= blk_nxt;
            outReqReady     <= req_ready_c;
            outCoreDataWr   <= core_wr_c;
            outCoreData     <= core_data_c;
            outCoreAesMode  <= core_mode_c;
            outCoreKeyData0 <= key0_c;
            outCoreKeyData1 <= key1_c;
            outResValid     <= res_valid_c;
            outResData      <= res_data_c;
            outErr          <= err_c;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        mode_nxt  = mode;
        blk_nxt   = blk;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_fire_c) begin
                    state_nxt = ISSUE;
                    cnt_nxt   = '0;
                    mode_nxt  = inReqMode;
                    blk_nxt   = inReqData;
                end
            end
            ISSUE: begin
                if (cnt == RK_IDX_W'(ISSUE_LAST)) begin
                    state_nxt = WAIT;
                    tcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + RK_IDX_W'(1);
                end
            end
            WAIT: begin
                if (!inCoreBusy) begin
                    capture_c = 1'b1;
                    state_nxt = HOLD;
                end else if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_c = 1'b1;
                    capture_c = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            HOLD: begin
                if (inResReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the upcoming state, registered on the same edge.
    always_comb begin
        req_ready_c = 1'b0;
        core_wr_c   = 1'b0;
        core_data_c = '0;
        core_mode_c = 1'b0;
        key0_c      = '0;
        key1_c      = '0;
        res_valid_c = 1'b0;
        res_data_c  = capture_c ? inCoreData : outResData;
        err_c       = outErr | key_bad_c | timeout_c;
        rd_idx0_c   = rk_idx0(mode_nxt, cnt_nxt);
        rd_idx1_c   = rk_idx1(mode_nxt);
        case (state_nxt)
            IDLE: req_ready_c = keys_ready_c;
            ISSUE: begin
                core_mode_c = mode_nxt;
                key0_c      = rk0_c;
                if (cnt_nxt == '0) begin
                    core_wr_c   = 1'b1;
                    core_data_c = blk_nxt;
                    key1_c      = rk1_c;
                end
            end
            WAIT: core_mode_c = mode_nxt;
            HOLD: begin
                core_mode_c = mode_nxt;
                res_valid_c = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Scoreboard bench for aes_round_key_sequencer with a behavioural core (busy/data) model.
module tb_aes_round_key_sequencer;
    import aes_ctrl_pkg::*;

    localparam int TO = 64;
    localparam logic [127:0] PT        = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT        = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] BUSY_DATA = 128'hdead_beef_0bad_f00d_cafe_babe_5a5a_a5a5;

    logic         inClk = 1'b0;
    logic         inRstN;
    logic         inKeyWr;
    logic [3:0]   inKeyIdx;
    logic [127:0] inKeyData;
    logic         inReqValid;
    logic         inReqMode;
    logic [127:0] inReqData;
    logic         outReqReady;
    logic         outCoreDataWr;
    logic [127:0] outCoreData;
    logic         outCoreAesMode;
    logic [127:0] outCoreKeyData0;
    logic [127:0] outCoreKeyData1;
    logic         inCoreBusy;
    logic [127:0] inCoreData;
    logic         outResValid;
    logic [127:0] outResData;
    logic         inResReady;
    logic         outErr;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic         err_exp = 1'b0;
    logic [127:0] rk [15];
    logic [127:0] sb_q [$];

    always #5 inClk = ~inClk;

    aes_round_key_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .inClk           (inClk),
        .inRstN          (inRstN),
        .inKeyWr         (inKeyWr),
        .inKeyIdx        (inKeyIdx),
        .inKeyData       (inKeyData),
        .inReqValid      (inReqValid),
        .inReqMode       (inReqMode),
        .inReqData       (inReqData),
        .outReqReady     (outReqReady),
        .outCoreDataWr   (outCoreDataWr),
        .outCoreData     (outCoreData),
        .outCoreAesMode  (outCoreAesMode),
        .outCoreKeyData0 (outCoreKeyData0),
        .outCoreKeyData1 (outCoreKeyData1),
        .inCoreBusy      (inCoreBusy),
        .inCoreData      (inCoreData),
        .outResValid     (outResValid),
        .outResData      (outResData),
        .inResReady      (inResReady),
        .outErr          (outErr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"},  128'(outReqReady),    128'(0));
        check({tag, " wr"},     128'(outCoreDataWr),  128'(0));
        check({tag, " data"},   outCoreData,          '0);
        check({tag, " mode"},   128'(outCoreAesMode), 128'(0));
        check({tag, " key0"},   outCoreKeyData0,      '0);
        check({tag, " key1"},   outCoreKeyData1,      '0);
        check({tag, " rvalid"}, 128'(outResValid),    128'(0));
        check({tag, " rdata"},  outResData,           '0);
        check({tag, " err"},    128'(outErr),         128'(0));
    endtask

    task automatic write_key(input int idx, input logic [127:0] data);
        inKeyWr   = 1'b1;
        inKeyIdx  = 4'(idx);
        inKeyData = data;
        tick();
        inKeyWr   = 1'b0;
    endtask

    task automatic load_keys();
        for (int i = 0; i < 15; i++) write_key(i, rk[i]);
    endtask

    // One block request; rst_at >= 0 aborts with a reset at that issue count.
    task automatic run_req(input string tag, input logic md, input logic [127:0] blk,
                           input logic [127:0] res, input int busy_n, input logic bad_kw,
                           input logic kw_same, input int rst_at);
        int           w;
        int           ki;
        logic         exp_to;
        logic [127:0] k0;
        logic [127:0] k1;
        w = 0;
        while (!outReqReady && w < 50) begin
            tick();
            w++;
        end
        check({tag, " ready"}, 128'(outReqReady), 128'(1));
        exp_to     = (busy_n >= TO);
        inReqValid = 1'b1;
        inReqMode  = md;
        inReqData  = blk;
        if (kw_same) begin
            inKeyWr   = 1'b1;
            inKeyIdx  = 4'd0;
            inKeyData = rk[0];
        end
        sb_q.push_back(exp_to ? BUSY_DATA : res);
        inCoreBusy = 1'b1;
        inCoreData = BUSY_DATA;
        tick();
        inReqValid = 1'b0;
        inReqData  = '0;
        inKeyWr    = 1'b0;
        check({tag, " ready low"}, 128'(outReqReady), 128'(0));
        for (int c = 0; c <= 13; c++) begin
            if (c == rst_at) begin
                inRstN = 1'b0;
                #1;
                check_all_zero({tag, " rst"});
                err_exp    = 1'b0;
                inCoreBusy = 1'b0;
                void'(sb_q.pop_back());
                tick();
                inRstN = 1'b1;
                return;
            end
            if (md) ki = (c == 0) ? 14 : 13 - c;
            else    ki = (c == 0) ? 0 : c + 1;
            k0 = rk[ki];
            k1 = (c == 0) ? (md ? rk[13] : rk[1]) : '0;
            check($sformatf("%s key0 c%0d", tag, c), outCoreKeyData0, k0);
            check($sformatf("%s key1 c%0d", tag, c), outCoreKeyData1, k1);
            check($sformatf("%s wr c%0d", tag, c), 128'(outCoreDataWr), 128'(c == 0));
            check($sformatf("%s data c%0d", tag, c), outCoreData, (c == 0) ? blk : '0);
            check($sformatf("%s mode c%0d", tag, c), 128'(outCoreAesMode), 128'(md));
            if (bad_kw && c == 2) check({tag, " err rise"}, 128'(outErr), 128'(1));
            if (bad_kw && c == 1) begin
                inKeyWr   = 1'b1;
                inKeyIdx  = 4'd3;
                inKeyData = ~rk[3];
            end else begin
                inKeyWr = 1'b0;
            end
            tick();
        end
        if (bad_kw) err_exp = 1'b1;
        if (exp_to) err_exp = 1'b1;
        check({tag, " wait key0"}, outCoreKeyData0, '0);
        check({tag, " wait wr"},   128'(outCoreDataWr), 128'(0));
        check({tag, " wait mode"}, 128'(outCoreAesMode), 128'(md));
        w = 0;
        while (!outResValid && w < 200) begin
            if (w >= busy_n) begin
                inCoreBusy = 1'b0;
                inCoreData = res;
            end
            tick();
            w++;
        end
        check({tag, " latency"}, 128'(w), exp_to ? 128'(TO) : 128'(busy_n + 1));
        check({tag, " err"}, 128'(outErr), 128'(err_exp));
        check({tag, " sb"}, 128'(sb_q.size()), 128'(1));
        if (sb_q.size() != 0) check({tag, " result"}, outResData, sb_q.pop_front());
        inCoreBusy = 1'b0;
        inCoreData = '0;
        tick();
        check({tag, " hold valid"}, 128'(outResValid), 128'(1));
        check({tag, " hold mode"}, 128'(outCoreAesMode), 128'(md));
        inResReady = 1'b1;
        tick();
        inResReady = 1'b0;
        check({tag, " idle valid"}, 128'(outResValid), 128'(0));
        check({tag, " idle ready"}, 128'(outReqReady), 128'(1));
        check({tag, " idle mode"}, 128'(outCoreAesMode), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] rblk;
        logic [127:0] rres;
        rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

        inRstN     = 1'b0;
        inKeyWr    = 1'b0;
        inKeyIdx   = '0;
        inKeyData  = '0;
        inReqValid = 1'b0;
        inReqMode  = 1'b0;
        inReqData  = '0;
        inCoreBusy = 1'b0;
        inCoreData = '0;
        inResReady = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        inRstN = 1'b1;
        tick();
`ifdef AES_RK_VALID_TRACK_EN
        check("track empty", 128'(outReqReady), 128'(0));
        for (int i = 0; i < 14; i++) write_key(i, rk[i]);
        check("track 14 keys", 128'(outReqReady), 128'(0));
        write_key(14, rk[14]);
        check("track 15 keys", 128'(outReqReady), 128'(1));
`else
        check("ready after reset", 128'(outReqReady), 128'(1));
        load_keys();
`endif

        run_req("enc fips", MODE_ENC, PT, CT, 0, 1'b0, 1'b0, -1);
        run_req("dec fips", MODE_DEC, CT, PT, 3, 1'b0, 1'b0, -1);
        run_req("enc badkw", MODE_ENC, PT, CT, 5, 1'b1, 1'b0, -1);
        run_req("enc after badkw", MODE_ENC, PT, CT, 1, 1'b0, 1'b0, -1);
        rblk = {$urandom, $urandom, $urandom, $urandom};
        rres = {$urandom, $urandom, $urandom, $urandom};
        run_req("enc busy63", MODE_ENC, rblk, rres, TO - 1, 1'b0, 1'b0, -1);
        run_req("dec timeout", MODE_DEC, CT, PT, 1000, 1'b0, 1'b0, -1);
        run_req("enc reset", MODE_ENC, PT, CT, 0, 1'b0, 1'b0, 7);
        tick();
        check("err cleared", 128'(outErr), 128'(0));
`ifdef AES_RK_VALID_TRACK_EN
        load_keys();
`endif
        run_req("enc post reset", MODE_ENC, PT, CT, 2, 1'b0, 1'b0, -1);
        rk[0] = {$urandom, $urandom, $urandom, $urandom};
        rres  = {$urandom, $urandom, $urandom, $urandom};
        run_req("enc same cyc kw", MODE_ENC, PT, rres, 0, 1'b0, 1'b1, -1);
        run_req("enc new rk0", MODE_ENC, CT, PT, 4, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
